// File: rtl/norm_sched_if.sv
// rtl/norm_sched_if.sv - request/result handshake bundle for norm_sched
interface norm_sched_if #(
  parameter int NREQ = 3,
  parameter int EW   = 8,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_sign;
  logic [NREQ*EW-1:0] req_exp;
  logic [NREQ*24-1:0] req_man;
  logic               out_valid;
  logic               out_ready;
  logic [IDW-1:0]     out_id;
  logic               out_sign;
  logic [EW-1:0]      out_exp;
  logic [23:0]        out_man;
  logic               out_zero;
  logic               out_uflow;

  modport master (
    output req_valid, req_sign, req_exp, req_man, out_ready,
    input  req_ready, out_valid, out_id, out_sign, out_exp, out_man, out_zero, out_uflow
  );

  modport slave (
    input  req_valid, req_sign, req_exp, req_man, out_ready,
    output req_ready, out_valid, out_id, out_sign, out_exp, out_man, out_zero, out_uflow
  );
endinterface

// File: rtl/norm_sched.sv
// rtl/norm_sched.sv - round-robin share of one leading-zero normalizer with credit-gated result FIFO
module norm_sched #(
  parameter int NREQ   = 3,
  parameter int EW     = 8,
  parameter int IDW    = 2,
  parameter int ODEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  norm_sched_if.slave bus,
  output logic [23:0] lz_v,
  input  logic [4:0]  lz_num,
  input  logic [23:0] lz_res,
  output logic        busy
);
  localparam int OW = $clog2(ODEPTH + 1);
  localparam int PW = (ODEPTH > 1) ? $clog2(ODEPTH) : 1;
  localparam int FW = IDW + 1 + EW + 24 + 2;

  logic [IDW-1:0] rr_ptr, gnt_id;
  logic           gnt_found, credit_ok, accept, push, pop, fifo_nempty;
  logic [OW-1:0]  occ, cnt;
  logic           sel_sign;
  logic [EW-1:0]  sel_exp;
  logic [23:0]    sel_man;

  // Two passes over the requesters: those above rr_ptr first, then wrap around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && bus.req_valid[i] && IDW'(i) > rr_ptr) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && bus.req_valid[i] && IDW'(i) <= rr_ptr) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(i);
      end
    end
  end

  assign credit_ok = occ < OW'(ODEPTH);
  assign accept    = gnt_found && credit_ok;

  always_comb begin
    bus.req_ready = '0;
    sel_sign      = 1'b0;
    sel_exp       = '0;
    sel_man       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        bus.req_ready[i] = accept;
        sel_sign         = bus.req_sign[i];
        sel_exp          = bus.req_exp[i*EW +: EW];
        sel_man          = bus.req_man[i*24 +: 24];
      end
    end
  end

  logic           s1_valid, s2_valid, s1_sign, s2_sign;
  logic [IDW-1:0] s1_id, s2_id;
  logic [EW-1:0]  s1_exp, s2_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= IDW'(NREQ - 1);
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s2_sign  <= 1'b0;
      s1_id    <= '0;
      s2_id    <= '0;
      s1_exp   <= '0;
      s2_exp   <= '0;
      lz_v     <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_id    <= s1_id;
      s2_exp   <= s1_exp;
      if (accept) begin
        rr_ptr  <= gnt_id;
        s1_id   <= gnt_id;
        s1_sign <= sel_sign;
        s1_exp  <= sel_exp;
        lz_v    <= sel_man;
      end
    end
  end

  logic [EW:0]   diff;
  logic          r_zero, r_uflow;
  logic [EW-1:0] r_exp;
  logic [23:0]   r_man;

  always_comb begin
    diff    = {1'b0, s2_exp} - {{(EW-4){1'b0}}, lz_num};
    r_zero  = 1'b0;
    r_uflow = 1'b0;
    r_exp   = diff[EW-1:0];
    r_man   = lz_res;
    if (lz_num == 5'd24) begin
      r_zero = 1'b1;
      r_exp  = '0;
      r_man  = '0;
    end else if (diff[EW] || diff == '0) begin
      r_uflow = 1'b1;
      r_exp   = '0;
      r_man   = '0;
    end
  end

  logic [FW-1:0] mem [ODEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign push        = s2_valid;
  assign fifo_nempty = cnt != '0;
  assign pop         = fifo_nempty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s2_id, s2_sign, r_exp, r_man, r_zero, r_uflow};
  end

  // occ counts in-flight plus buffered entries, so a push always finds room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(ODEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(ODEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst && push) assert (cnt < OW'(ODEPTH));
  end

  assign bus.out_valid = fifo_nempty;
  assign {bus.out_id, bus.out_sign, bus.out_exp, bus.out_man, bus.out_zero, bus.out_uflow} =
         fifo_nempty ? mem[rd_ptr] : '0;
  assign busy = occ != '0;
endmodule

// File: tb/tb_norm_sched.sv
// tb/tb_norm_sched.sv - self-checking bench for norm_sched with a behavioural scoreboard
module tb_norm_sched;
  localparam int NREQ = 3, EW = 8, IDW = 2, ODEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] lz_v;
  logic [4:0]  lz_num;
  logic [23:0] lz_res;
  logic        busy;

  norm_sched_if #(.NREQ(NREQ), .EW(EW), .IDW(IDW)) bus ();

  norm_sched #(.NREQ(NREQ), .EW(EW), .IDW(IDW), .ODEPTH(ODEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .lz_v(lz_v),
    .lz_num(lz_num), .lz_res(lz_res), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
  endtask

  function automatic int clz24(input int m);
    for (int b = 23; b >= 0; b--) if (m[b]) return 23 - b;
    return 24;
  endfunction

  // external normalizer: registered, no enable, no reset
  always @(posedge clk) begin
    lz_num <= 5'(clz24(int'(lz_v)));
    lz_res <= (clz24(int'(lz_v)) == 24) ? 24'h0 : 24'(lz_v << clz24(int'(lz_v)));
  end

  typedef struct {
    int id; bit sign; int exp; int man; bit zero; bit uflow; int due;
  } item_t;

  function automatic item_t model_result(input int id, input bit s, input int e, input int m, input int due);
    item_t r;
    int n = clz24(m);
    int d = e - n;
    r.id = id; r.sign = s; r.due = due; r.zero = 0; r.uflow = 0;
    if (m == 0) begin r.zero = 1; r.exp = 0; r.man = 0; end
    else if (d <= 0) begin r.uflow = 1; r.exp = 0; r.man = 0; end
    else begin r.exp = d; r.man = (m << n) & 32'h00FF_FFFF; end
    return r;
  endfunction

  item_t mq[$];
  int    m_occ = 0;
  int    m_rr  = NREQ - 1;
  int    cyc   = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_occ = 0;
      m_rr  = NREQ - 1;
      check("m_rst_out_valid", bus.out_valid, 0);
      check("m_rst_busy", busy, 0);
      check("m_rst_req_ready", bus.req_ready, 0);
    end else begin
      logic [NREQ-1:0] exp_rdy;
      int  g;
      bit  ov, pop;
      exp_rdy = '0;
      g = -1;
      if (m_occ < ODEPTH)
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && bus.req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      if (g >= 0) exp_rdy[g] = 1'b1;
      ov = mq.size() > 0 && mq[0].due <= cyc;
      check("m_req_ready", bus.req_ready, exp_rdy);
      check("m_out_valid", bus.out_valid, ov);
      check("m_busy", busy, m_occ != 0);
      if (ov && bus.out_valid) begin
        check("m_out_id", bus.out_id, mq[0].id);
        check("m_out_sign", bus.out_sign, mq[0].sign);
        check("m_out_exp", bus.out_exp, mq[0].exp);
        check("m_out_man", bus.out_man, mq[0].man);
        check("m_out_zero", bus.out_zero, mq[0].zero);
        check("m_out_uflow", bus.out_uflow, mq[0].uflow);
      end
      pop = ov && bus.out_ready;
      if (pop) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back(model_result(g, bus.req_sign[g], int'(bus.req_exp[g*EW +: EW]),
                                  int'(bus.req_man[g*24 +: 24]), cyc + 3));
        m_rr = g;
      end
      m_occ = m_occ + (g >= 0 ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  task automatic set_req(input int i, input bit v, input bit s, input int e, input int m);
    bus.req_valid[i]          = v;
    bus.req_sign[i]           = s;
    bus.req_exp[i*EW +: EW]   = EW'(e);
    bus.req_man[i*24 +: 24]   = 24'(m);
  endtask

  task automatic send(input int i, input bit s, input int e, input int m);
    int n = 0;
    @(posedge clk); #1;
    set_req(i, 1'b1, s, e, m);
    do begin @(negedge clk); n++; end while (!bus.req_ready[i] && n < 50);
    if (!bus.req_ready[i]) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 20);
    if (!bus.out_valid) check("wait_out_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 50);
    check("drain_idle", busy, 0);
  endtask

  function automatic int rnd_man();
    int m = int'($urandom & 32'h00FF_FFFF);
    return m >> $urandom_range(0, 23);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, acc;
    logic [NREQ-1:0] r;
    bus.req_valid = '0; bus.req_sign = '0; bus.req_exp = '0; bus.req_man = '0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lz_v", lz_v, 0);
    check("rst_out_man", bus.out_man, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: basic normalize, fixed latency
    send(0, 1'b0, 127, 'h000F00);
    wait_out(lat);
    check("t1_latency", lat, 3);
    check("t1_id", bus.out_id, 0);
    check("t1_exp", bus.out_exp, 115);
    check("t1_man", bus.out_man, 'hF00000);
    check("t1_zero", bus.out_zero, 0);
    check("t1_uflow", bus.out_uflow, 0);

    // 2: zero, smallest normal, underflow
    send(1, 1'b1, 90, 0);
    wait_out(lat);
    check("t2a_id", bus.out_id, 1);
    check("t2a_zero", bus.out_zero, 1);
    check("t2a_exp", bus.out_exp, 0);
    check("t2a_man", bus.out_man, 0);
    send(2, 1'b0, 24, 1);
    wait_out(lat);
    check("t2b_exp", bus.out_exp, 1);
    check("t2b_man", bus.out_man, 'h800000);
    check("t2b_uflow", bus.out_uflow, 0);
    send(2, 1'b0, 23, 1);
    wait_out(lat);
    check("t2c_uflow", bus.out_uflow, 1);
    check("t2c_exp", bus.out_exp, 0);
    check("t2c_man", bus.out_man, 0);
    drain();

    // 3: all requesters busy, full throughput round robin
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, $urandom_range(0, 1), $urandom_range(0, 255), rnd_man());
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      r = bus.req_ready;
      check("t3_grant", r, 1 << (k % 3));
      check("t3_out_valid", bus.out_valid, k >= 3);
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++)
        if (r[i]) set_req(i, 1'b1, $urandom_range(0, 1), $urandom_range(0, 255), rnd_man());
    end
    bus.req_valid = '0;
    drain();

    // 4/5: credit exhaustion with consumer stalled, then pop-cycle behaviour
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 0, 200, rnd_man());
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      r = bus.req_ready;
      if (r[0]) acc++;
      @(posedge clk); #1;
      if (r[0]) set_req(0, 1'b1, $urandom_range(0, 1), $urandom_range(0, 255), rnd_man());
    end
    check("t4_accepts", acc, 4);
    @(negedge clk);
    check("t4_ready_full", bus.req_ready, 0);
    check("t4_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t5_ready_on_pop", bus.req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_ready_after_pop", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // 6: reset with work in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 0, 150, rnd_man());
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!bus.out_valid) begin @(posedge clk); #1; end
    end while (!bus.out_valid && lat < 20);
    check("t6_out_valid_before", bus.out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    check("t6_out_valid_rst", bus.out_valid, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_ready_rst", bus.req_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t6_no_stale", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 60 + i, rnd_man());
    @(negedge clk);
    check("t6_first_grant", bus.req_ready, 3'b001);
    repeat (2) begin @(posedge clk); #1; @(negedge clk); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
